// File: rtl/isqrt_rr_arbiter_if.sv
// Bundle of requester, response, shared-isqrt and status signals for isqrt_rr_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface isqrt_rr_arbiter_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req0_vld;
    logic [31:0]   req0_x;
    logic          req0_rdy;
    logic          req1_vld;
    logic [31:0]   req1_x;
    logic          req1_rdy;
    logic          resp0_vld;
    logic [15:0]   resp0_y;
    logic          resp1_vld;
    logic [15:0]   resp1_y;
    logic          isqrt_x_vld;
    logic [31:0]   isqrt_x;
    logic          isqrt_y_vld;
    logic [15:0]   isqrt_y;
    logic [CW-1:0] inflight;
    logic          err;

    modport slave (
        input  req0_vld, req0_x, req1_vld, req1_x, isqrt_y_vld, isqrt_y,
        output req0_rdy, req1_rdy, resp0_vld, resp0_y, resp1_vld, resp1_y,
               isqrt_x_vld, isqrt_x, inflight, err
    );

    modport master (
        output req0_vld, req0_x, req1_vld, req1_x, isqrt_y_vld, isqrt_y,
        input  req0_rdy, req1_rdy, resp0_vld, resp0_y, resp1_vld, resp1_y,
               isqrt_x_vld, isqrt_x, inflight, err
    );
endinterface

// File: rtl/isqrt_rr_arbiter.sv
// Two-requester round-robin front end for a shared in-order isqrt unit.
// Operands pass straight through on grant; a tag FIFO routes returning results.
module isqrt_rr_arbiter #(
    parameter int DEPTH = 8
) (
    input logic               clk,
    input logic               rst,
    isqrt_rr_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [CW-1:0] inflight_q, inflight_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          last_grant_q, last_grant_d;
    logic          err_q, err_d;
    logic          resp0_vld_q, resp0_vld_d;
    logic          resp1_vld_q, resp1_vld_d;
    logic [15:0]   resp0_y_q, resp0_y_d;
    logic [15:0]   resp1_y_q, resp1_y_d;
    logic          tag_q [DEPTH];

    logic gnt;
    logic accept;
    logic rdy0, rdy1;
    logic issue;
    logic pop;
    logic pop_tag;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt = 1'b0;
        if (bus.req0_vld && bus.req1_vld) begin
            gnt = ~last_grant_q;
        end else if (bus.req1_vld) begin
            gnt = 1'b1;
        end
    end

    // Accept depends only on the registered count, so a same-cycle result never frees a slot.
    assign accept  = !rst && (inflight_q < FULL_C);
    assign rdy0    = accept && bus.req0_vld && !gnt;
    assign rdy1    = accept && bus.req1_vld && gnt;
    assign issue   = rdy0 || rdy1;
    assign pop     = !rst && bus.isqrt_y_vld && (inflight_q != '0);
    assign pop_tag = tag_q[rd_ptr_q];

    always_comb begin
        inflight_d   = inflight_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        resp0_vld_d  = 1'b0;
        resp1_vld_d  = 1'b0;
        resp0_y_d    = resp0_y_q;
        resp1_y_d    = resp1_y_q;

        if (issue) begin
            wr_ptr_d     = wr_ptr_q + PW'(1);
            last_grant_d = gnt;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (pop_tag) begin
                resp1_vld_d = 1'b1;
                resp1_y_d   = bus.isqrt_y;
            end else begin
                resp0_vld_d = 1'b1;
                resp0_y_d   = bus.isqrt_y;
            end
        end
        if (issue && !pop) begin
            inflight_d = inflight_q + CW'(1);
        end else if (pop && !issue) begin
            inflight_d = inflight_q - CW'(1);
        end
        if (bus.isqrt_y_vld && (inflight_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            resp0_vld_q  <= 1'b0;
            resp1_vld_q  <= 1'b0;
            resp0_y_q    <= '0;
            resp1_y_q    <= '0;
        end else begin
            inflight_q   <= inflight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            resp0_vld_q  <= resp0_vld_d;
            resp1_vld_q  <= resp1_vld_d;
            resp0_y_q    <= resp0_y_d;
            resp1_y_q    <= resp1_y_d;
        end
    end

    // Tag storage holds data only; stale entries are harmless once the pointers reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_q[wr_ptr_q] <= gnt;
        end
    end

    assign bus.req0_rdy    = rdy0;
    assign bus.req1_rdy    = rdy1;
    assign bus.isqrt_x_vld = issue;
    assign bus.isqrt_x     = rdy1 ? bus.req1_x : (rdy0 ? bus.req0_x : 32'd0);
    assign bus.resp0_vld   = resp0_vld_q;
    assign bus.resp0_y     = resp0_y_q;
    assign bus.resp1_vld   = resp1_vld_q;
    assign bus.resp1_y     = resp1_y_q;
    assign bus.inflight    = inflight_q;
    assign bus.err         = err_err_unused_guard();

    function automatic logic err_err_unused_guard();
        return err_q;
    endfunction
endmodule

// File: doc/isqrt_rr_arbiter.md
ISQRT_RR_ARBITER -- requirements
Module: isqrt_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the maximum number of isqrt requests in flight (power of 2, 2..64).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_vld  input  1  requester 0 has operand.
REQ-005 req0_x  input  32  requester 0 operand.
REQ-006 req0_rdy  output  1  requester 0 operand accepted this cycle when req0_vld also high.
REQ-007 req1_vld, req1_x, req1_rdy  same as REQ-004..006 for requester 1.
REQ-008 resp0_vld  output  1  result for requester 0 valid, one-cycle pulse.
REQ-009 resp0_y  output  16  result for requester 0.
REQ-010 resp1_vld, resp1_y  same as REQ-008..009 for requester 1.
REQ-011 isqrt_x_vld  output  1  operand issue strobe to shared isqrt unit.
REQ-012 isqrt_x  output  32  operand to isqrt unit.
REQ-013 isqrt_y_vld  input  1  isqrt result strobe (in-order, fixed or variable latency, no backpressure).
REQ-014 isqrt_y  input  16  isqrt result.
REQ-015 inflight  output  $clog2(DEPTH)+1  number of issued, not yet returned requests.
REQ-016 err  output  1  sticky: result arrived with nothing in flight.

Function
REQ-017 Accept condition: inflight < DEPTH; when false, req0_rdy and req1_rdy SHALL both be 0, even if isqrt_y_vld is high that cycle.
REQ-018 Arbitration: round-robin with 1-bit last_grant register; only one valid -> that requester granted; both valid -> requester != last_grant granted.
REQ-019 reqN_rdy SHALL be combinational: accept condition AND grant to N; at most one rdy high per cycle.
REQ-020 reqN_rdy SHALL NOT depend on the other requester's rdy; it may be high with reqN_vld low only when N is the sole candidate? No: rdy SHALL be 0 for a requester whose vld is 0.
REQ-021 Issue: on accepted handshake, isqrt_x_vld=1 and isqrt_x=granted operand in the same cycle (zero-latency pass-through); otherwise isqrt_x_vld=0, isqrt_x=0.
REQ-022 On issue, last_grant SHALL update to the granted index and the index SHALL be pushed into a DEPTH-entry tag FIFO.
REQ-023 On isqrt_y_vld with inflight>0: pop tag; next cycle respT_vld=1, respT_y=isqrt_y (registered), other resp_vld=0.
REQ-024 Responses SHALL be delivered in issue order; requesters have no backpressure on resp.
REQ-025 inflight: +1 on issue only, -1 on pop only, unchanged on simultaneous issue and pop.
REQ-026 isqrt_y_vld with inflight==0: no pop, no resp pulse, err set to 1 and held until rst.
REQ-027 Tag FIFO pointers SHALL wrap modulo DEPTH; full/empty derived from inflight.
REQ-028 resp_y SHALL hold last value when resp_vld=0.

Reset
REQ-029 On rst: inflight=0, FIFO pointers=0, last_grant=1 (requester 0 wins first tie), err=0, resp0_vld=resp1_vld=0, resp0_y=resp1_y=0.
REQ-030 Reset mid-operation SHALL discard all in-flight tags; the isqrt unit is reset by the same rst, so no stale results are expected; any that arrive set err.
REQ-031 During rst-high cycles reqN_rdy and isqrt_x_vld SHALL be 0.

Verification
REQ-032 Single: req0 x=144 one cycle -> isqrt_x_vld with 144 same cycle; isqrt_y=12 returned -> resp0_vld pulse next cycle, resp0_y=12, resp1_vld=0.
REQ-033 Tie: req0 x=16, req1 x=81 held valid from reset -> issue order 16 (req0), 81 (req1), alternating; results 4 to req0, 9 to req1 in order.
REQ-034 Full: DEPTH=8, req0 continuously valid, no results -> exactly 8 issues, then req0_rdy=0 and inflight=8; one result returned -> inflight 7 next cycle, one more issue accepted.
REQ-035 Simultaneous: inflight=3, issue and isqrt_y_vld same cycle -> inflight stays 3, correct tag popped.
REQ-036 Stray result: after rst, isqrt_y_vld=1 y=5 -> no resp pulse, err=1 sticky until next rst.
REQ-037 Random: 2000 cycles random vld on both ports, random isqrt latency 1..20 in-order model -> every resp matches floor(sqrt(x)) of its own requester's operand, order preserved per requester, no requester starved longer than one grant while other valid.
